// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared constants, recorder state encoding and the table entry
//               layout used by the event recorder and its table.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef EXTENDED_SINGLE
`define EXTENDED_SINGLE 64
`endif

package ctrl_pkg;

    localparam int DEPTH = 14;
    localparam int TW    = 12;
    localparam int DW    = `EXTENDED_SINGLE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        DONE = 2'd2
    } rec_state_t;

    // One schedule point: the counter value at which `value` takes effect.
    typedef struct packed {
        logic [TW-1:0] t;
        logic [DW-1:0] value;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/rec_table_14.sv
`default_nettype none
// ============================================================================
// Module      : rec_table_14
// Description : DEPTH-entry (time, value) register file, entries 1..DEPTH.
//               One write port, synchronous clear, one registered read port.
//               Out-of-range read indices return all zeros.
// Revision    : 1.0 - initial release
// ============================================================================

module rec_table_14
    import ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          sta_n,
    input  logic          clr,
    input  logic          we,
    input  logic [3:0]    wr_idx,
    input  logic [TW-1:0] wr_time,
    input  logic [DW-1:0] wr_value,
    input  logic [3:0]    rd_idx,
    output logic [TW-1:0] rd_time,
    output logic [DW-1:0] rd_value
);

    entry_t w_entries [1:DEPTH];
    entry_t w_rd_sel;
    entry_t r_rd;

    generate
        for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_entry
            entry_t r_entry;

            // Entry storage: cleared by reset or clear, loaded when addressed.
            always_ff @(posedge clk) begin
                if (!sta_n || clr) begin
                    r_entry <= '0;
                end else if (we && (wr_idx == 4'(gi))) begin
                    r_entry <= {wr_time, wr_value};
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

    // Read mux; index 0 and indices above DEPTH fall through to zero.
    always_comb begin
        w_rd_sel = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (rd_idx == 4'(i)) begin
                w_rd_sel = w_entries[i];
            end
        end
    end

    // Registered read port; a same-cycle write is seen on the following read.
    always_ff @(posedge clk) begin
        if (!sta_n) begin
            r_rd <= '0;
        end else begin
            r_rd <= w_rd_sel;
        end
    end

    assign rd_time  = r_rd.t;
    assign rd_value = r_rd.value;

endmodule

`default_nettype wire

// File: rtl/ctrl_event_rec_14.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_event_rec_14
// Description : Event recorder. While recording, every change of the sampled
//               value stream is stored as a (counter, value) pair, producing a
//               piecewise-constant schedule that a player can replay. Rejects
//               non-increasing times and flags changes lost to a full table.
// Revision    : 1.0 - initial release
// ============================================================================

module ctrl_event_rec_14
    import ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          sta_n,
    input  logic          arm,
    input  logic          stop,
    input  logic [TW-1:0] counter,
    input  logic          sample_en,
    input  logic [DW-1:0] x,
    input  logic [3:0]    rd_idx,
    output logic [TW-1:0] rd_time,
    output logic [DW-1:0] rd_value,
    output logic [3:0]    count,
    output logic          busy,
    output logic          full,
    output logic          overflow,
    output logic          order_err
);

    localparam logic [3:0] c_depth = 4'(DEPTH);

    rec_state_t    r_state;
    rec_state_t    w_state_nxt;
    logic          w_clr;

    logic [3:0]    r_count;
    logic [DW-1:0] r_prev;
    logic [TW-1:0] r_last_t;
    logic          r_overflow;
    logic          r_order_err;

    logic          w_full;
    logic          w_change;
    logic          w_order_bad;
    logic          w_we;

    // Next state: arm restarts from any state and beats stop.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        if (arm) begin
            w_state_nxt = REC;
            w_clr       = 1'b1;
        end else if ((r_state == REC) && stop) begin
            w_state_nxt = DONE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!sta_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A change is only considered while recording; the arm cycle drops its sample.
    assign w_full      = (r_count == c_depth);
    assign w_change    = (r_state == REC) && sample_en && !arm && (x != r_prev);
    assign w_order_bad = (counter == '0) || (counter <= r_last_t);
    assign w_we        = w_change && !w_order_bad && !w_full;

    // Recording bookkeeping: fill level, last accepted value/time, sticky flags.
    always_ff @(posedge clk) begin
        if (!sta_n || w_clr) begin
            r_count     <= '0;
            r_prev      <= '0;
            r_last_t    <= '0;
            r_overflow  <= 1'b0;
            r_order_err <= 1'b0;
        end else begin
            if (w_we) begin
                r_count  <= r_count + 4'd1;
                r_prev   <= x;
                r_last_t <= counter;
            end
            if (w_change && w_order_bad) begin
                r_order_err <= 1'b1;
            end
            if (w_change && !w_order_bad && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    rec_table_14 u_table (
        .clk      (clk),
        .sta_n    (sta_n),
        .clr      (w_clr),
        .we       (w_we),
        .wr_idx   (r_count + 4'd1),
        .wr_time  (counter),
        .wr_value (x),
        .rd_idx   (rd_idx),
        .rd_time  (rd_time),
        .rd_value (rd_value)
    );

    assign count     = r_count;
    assign busy      = (r_state == REC);
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign order_err = r_order_err;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_event_rec_14.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_event_rec_14
// Description : Self-checking bench for ctrl_event_rec_14. Table reads go
//               through a scoreboard queue; status outputs are checked
//               directly against values derived from the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_ctrl_event_rec_14;
    import ctrl_pkg::*;

    localparam logic [DW-1:0] c_a = 64'h3FF0_0000_0000_0000;
    localparam logic [DW-1:0] c_b = 64'hBFF0_0000_0000_0000;
    localparam logic [DW-1:0] c_c = 64'h7FF8_0000_0000_0001;

    logic          clk = 1'b0;
    logic          sta_n;
    logic          arm;
    logic          stop;
    logic [TW-1:0] counter;
    logic          sample_en;
    logic [DW-1:0] x;
    logic [3:0]    rd_idx;
    logic [TW-1:0] rd_time;
    logic [DW-1:0] rd_value;
    logic [3:0]    count;
    logic          busy;
    logic          full;
    logic          overflow;
    logic          order_err;

    int n_chk = 0;
    int n_err = 0;

    string             sb_tag [$];
    logic [TW+DW-1:0]  sb_exp [$];

    logic [TW-1:0] tt [1:DEPTH];
    logic [DW-1:0] vv [1:DEPTH];

    ctrl_event_rec_14 dut (
        .clk       (clk),
        .sta_n     (sta_n),
        .arm       (arm),
        .stop      (stop),
        .counter   (counter),
        .sample_en (sample_en),
        .x         (x),
        .rd_idx    (rd_idx),
        .rd_time   (rd_time),
        .rd_value  (rd_value),
        .count     (count),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow),
        .order_err (order_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [TW+DW-1:0] act, input logic [TW+DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [TW-1:0] t, input logic [DW-1:0] v);
        counter   = t;
        x         = v;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Issue a read, queue its expectation, then retire it one cycle later.
    task automatic rd(input string tag, input logic [3:0] idx,
                      input logic [TW-1:0] et, input logic [DW-1:0] ev);
        rd_idx = idx;
        sb_tag.push_back(tag);
        sb_exp.push_back({et, ev});
        tick();
        chk(sb_tag.pop_front(), {rd_time, rd_value}, sb_exp.pop_front());
    endtask

    function automatic logic [DW-1:0] seq2(input int t);
        if (t < 5)       return '0;
        else if (t < 9)  return c_a;
        else if (t < 20) return c_b;
        else             return c_c;
    endfunction

    initial begin
        sta_n = 1'b0; arm = 1'b0; stop = 1'b0; counter = '0;
        sample_en = 1'b0; x = '0; rd_idx = 4'd1;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_oerr", order_err, 0);
        chk("rst_rd", {rd_time, rd_value}, 0);
        sta_n = 1'b1;
        rd("rst_entry1", 4'd1, 0, 0);

        // Step sequence, with x=0 before t=5 producing nothing.
        pulse_arm();
        chk("arm_busy", busy, 1);
        for (int t = 1; t <= 25; t++) begin
            step(TW'(t), seq2(t));
            if (t == 4) chk("zero_no_entry", count, 0);
            if (t == 5) chk("first_write", count, 1);
        end
        chk("step_count", count, 3);
        rd("e1", 4'd1, 12'd5,  c_a);
        rd("e2", 4'd2, 12'd9,  c_b);
        rd("e3", 4'd3, 12'd20, c_c);
        rd("e4", 4'd4, 12'd0,  '0);
        rd("e0", 4'd0, 12'd0,  '0);

        // Replay the recorded table through a player model on the same counter.
        for (int k = 1; k <= DEPTH; k++) begin
            rd_idx = 4'(k);
            tick();
            tt[k] = rd_time;
            vv[k] = rd_value;
        end
        for (int t = 1; t <= 25; t++) begin
            logic [DW-1:0] pv;
            pv = '0;
            for (int k = 1; k <= DEPTH; k++)
                if (tt[k] != 0 && tt[k] <= TW'(t)) pv = vv[k];
            chk($sformatf("replay_t%0d", t), pv, seq2(t));
        end

        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        step(12'd30, 64'hDEAD);
        chk("done_ignores", count, 3);

        // Repeated value held for 100 cycles.
        pulse_arm();
        chk("rearm_count", count, 0);
        for (int t = 5; t < 105; t++) step(TW'(t), c_a);
        chk("repeat_count", count, 1);
        rd("repeat_e1", 4'd1, 12'd5, c_a);

        // Overflow with 15 distinct changes.
        pulse_arm();
        for (int t = 1; t <= 15; t++) begin
            step(TW'(t), DW'(t));
            if (t == 14) chk("ovf_not_yet", overflow, 0);
        end
        chk("ovf_count", count, 14);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_busy", busy, 1);
        chk("ovf_oerr", order_err, 0);
        rd("ovf_e14", 4'd14, 12'd14, 64'd14);
        rd("ovf_e15", 4'd15, 12'd0, '0);

        // Order errors: counter zero, then time going backwards after a wrap.
        pulse_arm();
        chk("arm_clears_ovf", overflow, 0);
        step(12'd0, c_a);
        chk("zero_oerr", order_err, 1);
        chk("zero_count", count, 0);
        pulse_arm();
        chk("arm_clears_oerr", order_err, 0);
        step(12'd50, c_a);
        step(12'd4095, c_a);
        step(12'd10, c_b);
        chk("wrap_oerr", order_err, 1);
        chk("wrap_count", count, 1);
        rd("wrap_e2", 4'd2, 12'd0, '0);

        // arm during REC drops the sample of that cycle.
        counter = 12'd60; x = c_c; sample_en = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0; sample_en = 1'b0;
        chk("rearm_drop", count, 0);

        // arm and stop together: arm wins.
        arm = 1'b1; stop = 1'b1;
        tick();
        arm = 1'b0; stop = 1'b0;
        chk("armstop_busy", busy, 1);
        for (int t = 1; t <= 5; t++) step(TW'(t), DW'(t + 100));
        chk("pre_rst_count", count, 5);

        // Reset mid-REC beats arm and stop.
        sta_n = 1'b0; arm = 1'b1; stop = 1'b1;
        tick();
        sta_n = 1'b1; arm = 1'b0; stop = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count, 0);
        chk("midrst_full", full, 0);
        chk("midrst_rd", {rd_time, rd_value}, 0);
        rd("midrst_e1", 4'd1, 12'd0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ctrl_event_rec_14.md
# ctrl_event_rec_14

Event recorder that builds a 14-entry piecewise-constant schedule (time, value pairs) from a live 64-bit value stream against the shared 12-bit step counter. It feeds the time-scheduled value players: its table is laid out so entries 1..14 map directly onto a player's time_k/value_k inputs, with an implicit value 0 before the first entry. It sits beside the player on the same counter bus and captures a reference waveform during a run for later replay.

## Interface
- DEPTH, 14: number of table entries.
- TW, 12: counter/time width.
- DW, `EXTENDED_SINGLE (64): value width.

- clk  in  1  system clock, rising edge.
- sta_n  in  1  synchronous active-low reset.
- arm  in  1  pulse: clear table and start recording.
- stop  in  1  pulse: end recording.
- counter  in  TW  shared step counter.
- sample_en  in  1  x valid this cycle.
- x  in  DW  value stream being recorded.
- rd_idx  in  4  table read index, 1..DEPTH.
- rd_time  out  TW  registered time of entry rd_idx.
- rd_value  out  DW  registered value of entry rd_idx.
- count  out  4  entries written.
- busy  out  1  state is REC.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: change lost because the table was full.
- order_err  out  1  sticky: change rejected, time not strictly increasing or counter == 0.

## Operation
- States: IDLE, REC, DONE. Reset -> IDLE.
- IDLE/DONE + arm -> REC. On arm: all entries cleared to time 0, value 0; count, overflow and order_err cleared; prev (last recorded value) = 0; last_t = 0.
- REC + stop -> DONE. arm and stop in the same cycle: arm wins (restart).
- arm in REC: restart exactly as from IDLE; the sample in that cycle is ignored.
- Change detect: in REC with sample_en and x != prev:
  - counter == 0 or counter <= last_t: order_err = 1, no write, prev unchanged.
  - else if count == DEPTH: overflow = 1, no write. State stays REC.
  - else: entry[count+1] = {counter, x}; count++; prev = x; last_t = counter.
- x == prev: no action. Values compared bitwise (64-bit equality; no floating-point semantics).
- Counter wrap (4095 -> 0) during REC is not treated specially. A change after a wrap triggers order_err by the rules above.
- DONE holds the table until the next arm. sample_en is ignored outside REC.
- Reads are legal in any state. rd_idx of 0 or greater than DEPTH returns time 0, value 0.

## Timing
- Reset values: busy 0, full 0, count 0, overflow 0, order_err 0, rd_time 0, rd_value 0. All table entries are 0.
- Write: entry, count, full and the flags update on the edge after the qualifying sample.
- busy rises the cycle after arm and falls the cycle after stop.
- Read latency: 1 cycle, from rd_idx to rd_time/rd_value.
- A read of an entry being written in the same cycle returns the old contents.
- Reset applied mid-REC clears everything on that edge. It takes priority over arm and stop.
- Replay equivalence: feeding the table to a player produces the same value sequence at each recorded time, up to the player's fixed pipeline latency.

## Structure
- Shared package ctrl_pkg:
  - constants DEPTH and TW, with DW tied to `EXTENDED_SINGLE;
  - state enum rec_state_t {IDLE, REC, DONE};
  - entry struct {time[TW], value[DW]}.
- Sub-module rec_table_14: 14-entry register file with one write port, a synchronous clear, and one registered read port.
- Top level contains the FSM, change detector, and order/overflow checks.

## Test plan
- Step sequence: arm; changes 0→A at t=5, A→B at t=9, B→C at t=20 → count=3; entries 1..3 = (5,A), (9,B), (20,C); entry 4 reads (0,0).
- Repeated value: x held at A for 100 cycles after t=5 → only one entry; x=0 at t=3 from arm → no entry, since prev=0.
- Overflow: 15 distinct changes at t=1..15 → count=14, full=1, overflow=1; entry 14 = t=14 value.
- Order: change at counter=0 → order_err=1, count=0. After a recorded t=50, a wrap and a change at t=10 → order_err=1, no write.
- Control: arm and stop in the same cycle → REC, busy=1. Reset asserted mid-REC with count=5 → count=0, all outputs 0 the next cycle.
- Replay loopback: recorded table drives a player on the same counter → player output matches the recorded x sequence.
